xadc_drp_scheduler: RTL

Sequences and arbitrates the XADC dynamic reconfiguration port (DRP) between two requesters. The first is the automatic sample reader: on every end-of-sequence it reads the UA and UB result registers back-to-back and publishes both codes together. The second is a host configuration port for arbitrary DRP reads and writes. The block sits between the XADC primitive's DRP pins and the two-phase sampling logic, so that no other logic drives den/dwe/daddr directly.

---
 rtl/xadc_drp_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler: owns the XADC DRP port and shares it between the
// end-of-sequence UA/UB sample reader (strict priority) and a host port.
module xadc_drp_scheduler #(
    parameter logic [6:0]  UA_ADDR = 7'h1C,
    parameter logic [6:0]  UB_ADDR = 7'h1D,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        eos,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic        host_err,
    output logic [15:0] host_rdata,
    output logic [11:0] ua_code,
    output logic [11:0] ub_code,
    output logic        sample_valid,
    output logic        sample_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned   CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_UA_REQ  = 3'd1;
    localparam logic [2:0] S_UA_WAIT = 3'd2;
    localparam logic [2:0] S_UB_REQ  = 3'd3;
    localparam logic [2:0] S_UB_WAIT = 3'd4;
    localparam logic [2:0] S_H_REQ   = 3'd5;
    localparam logic [2:0] S_H_WAIT  = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic          r_pending;
    logic          w_pending_next;
    logic [CW-1:0] r_cnt;
    logic [11:0]   r_stage;
    logic          r_h_we;

    logic          r_den;
    logic          r_dwe;
    logic [6:0]    r_daddr;
    logic [15:0]   r_di;
    logic [11:0]   r_ua_code;
    logic [11:0]   r_ub_code;
    logic          r_sample_valid;
    logic          r_overrun;
    logic          r_busy;

    logic          w_den;
    logic          w_dwe;
    logic [6:0]    w_daddr;
    logic [15:0]   w_di;
    logic          w_last;
    logic          w_ua_done;
    logic          w_ub_done;
    logic          w_s_abort;
    logic          w_h_done;
    logic          w_h_abort;
    logic          w_enter_ua;
    logic          w_overrun;
    logic          w_in_wait;

    // Next state, DRP strobes for the upcoming state and pending-sample bookkeeping
    always_comb begin
        w_next         = r_state;
        w_den          = 1'b0;
        w_dwe          = 1'b0;
        w_daddr        = '0;
        w_di           = '0;
        w_ua_done      = 1'b0;
        w_ub_done      = 1'b0;
        w_s_abort      = 1'b0;
        w_h_done       = 1'b0;
        w_h_abort      = 1'b0;
        w_last         = (r_cnt == CNT_LAST);
        w_in_wait      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pending || eos) begin
                    w_next = S_UA_REQ;
                end else if (host_req) begin
                    w_next = S_H_REQ;
                end
            end
            S_UA_REQ: w_next = S_UA_WAIT;
            S_UA_WAIT: begin
                w_in_wait = 1'b1;
                if (drp_drdy) begin
                    w_ua_done = 1'b1;
                    w_next    = S_UB_REQ;
                end else if (w_last) begin
                    w_s_abort = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_UB_REQ: w_next = S_UB_WAIT;
            S_UB_WAIT: begin
                w_in_wait = 1'b1;
                if (drp_drdy) begin
                    w_ub_done = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_last) begin
                    w_s_abort = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_H_REQ: w_next = S_H_WAIT;
            S_H_WAIT: begin
                w_in_wait = 1'b1;
                if (drp_drdy) begin
                    w_h_done = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_last) begin
                    w_h_abort = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        case (w_next)
            S_UA_REQ: begin
                w_den   = 1'b1;
                w_daddr = UA_ADDR;
            end
            S_UB_REQ: begin
                w_den   = 1'b1;
                w_daddr = UB_ADDR;
            end
            S_H_REQ: begin
                w_den   = 1'b1;
                w_dwe   = host_we;
                w_daddr = host_addr;
                w_di    = host_wdata;
            end
            default: ;
        endcase

        // An eos that lands on the cycle the pending sample is consumed stays pending
        w_enter_ua     = (r_state == S_IDLE) && (w_next == S_UA_REQ);
        w_overrun      = eos && r_pending && !w_enter_ua;
        w_pending_next = w_enter_ua ? (r_pending && eos) : (r_pending || eos);
    end

    // State, pending flag and drdy wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_in_wait ? (r_cnt + CW'(1)) : '0;
        end
    end

    // Registered DRP strobes, sample codes and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_den          <= 1'b0;
            r_dwe          <= 1'b0;
            r_daddr        <= '0;
            r_di           <= '0;
            r_stage        <= '0;
            r_h_we         <= 1'b0;
            r_ua_code      <= '0;
            r_ub_code      <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_den          <= w_den;
            r_dwe          <= w_dwe;
            r_daddr        <= w_daddr;
            r_di           <= w_di;
            r_sample_valid <= w_ub_done;
            r_overrun      <= w_overrun;
            r_busy         <= (w_next != S_IDLE);
            if (w_next == S_H_REQ) begin
                r_h_we <= host_we;
            end
            if (w_ua_done) begin
                r_stage <= drp_do[15:4];
            end
            if (w_ub_done) begin
                r_ua_code <= r_stage;
                r_ub_code <= drp_do[15:4];
            end
        end
    end

    // Host completion is reported in the drdy (or timeout) cycle itself
    assign host_ack     = w_h_done || w_h_abort;
    assign host_err     = w_h_abort;
    assign host_rdata   = (w_h_done && !r_h_we) ? drp_do : '0;
    assign sample_err   = w_s_abort;

    assign drp_den      = r_den;
    assign drp_dwe      = r_dwe;
    assign drp_daddr    = r_daddr;
    assign drp_di       = r_di;
    assign ua_code      = r_ua_code;
    assign ub_code      = r_ub_code;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;
    assign busy         = r_busy;

endmodule
